// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Collects ALU and LSU results and feeds them, one per cycle and in
//   acceptance order, to the single write port of the register file. A small
//   circular FIFO absorbs cycles where both units complete together. Decode
//   can look up entries that are queued but not yet written.
//
// Handshake: a source transfers on a rising edge when its valid and ready are
//   both high. ready depends only on the registered fill level (and, for the
//   ALU, on lsu_valid). It never depends on the same cycle's dequeue. A
//   transfer with rd == 0 completes the handshake but is dropped.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   lsu_valid/rd/data/ready  LSU result handshake (priority for the last slot)
//   alu_valid/rd/data/ready  ALU result handshake
//   q_rs1, q_rs2             decode lookup addresses
//   rs1_hit/fwd, rs2_hit/fwd pending-write hit and youngest queued data
//   addr_rd, data_rd         register-file write address/data (head entry)
//   write_enable             register-file write strobe (queue non-empty)
module reg_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid,
    input  logic [4:0]        lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic [4:0]        q_rs1,
    input  logic [4:0]        q_rs2,
    output logic              rs1_hit,
    output logic              rs2_hit,
    output logic [DATA_W-1:0] rs1_fwd,
    output logic [DATA_W-1:0] rs2_fwd,
    output logic [4:0]        addr_rd,
    output logic [DATA_W-1:0] data_rd,
    output logic              write_enable
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [CW-1:0]     free;
    logic              lsu_enq;
    logic              alu_enq;
    logic [PW-1:0]     alu_slot;

    // Space is judged on the registered count only; the entry leaving this
    // cycle does not make room for an arrival in the same cycle.
    assign free      = DEPTH_C - count_q;
    assign lsu_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !lsu_valid);

    assign lsu_enq = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign alu_enq = alu_valid && alu_ready && (alu_rd != 5'd0);

    assign write_enable = (count_q != '0);
    assign addr_rd      = write_enable ? rd_q[head_q]   : 5'd0;
    assign data_rd      = write_enable ? data_q[head_q] : '0;

    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        alu_slot = tail_q;
        // LSU takes the older slot when both arrive together.
        if (lsu_enq) begin
            rd_d[tail_q]   = lsu_rd;
            data_d[tail_q] = lsu_data;
            alu_slot       = tail_q + PW'(1);
        end
        if (alu_enq) begin
            rd_d[alu_slot]   = alu_rd;
            data_d[alu_slot] = alu_data;
        end
        tail_d  = tail_q + PW'(lsu_enq) + PW'(alu_enq);
        head_d  = head_q + PW'(write_enable);
        count_d = count_q + CW'(lsu_enq) + CW'(alu_enq) - CW'(write_enable);
    end

    // Walk from head (oldest) toward tail so the last match is the youngest.
    // The head entry being written this cycle still counts as pending.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rs1_fwd = '0;
        rs2_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((q_rs1 != 5'd0) && (rd_q[head_q + PW'(i)] == q_rs1)) begin
                    rs1_hit = 1'b1;
                    rs1_fwd = data_q[head_q + PW'(i)];
                end
                if ((q_rs2 != 5'd0) && (rd_q[head_q + PW'(i)] == q_rs2)) begin
                    rs2_hit = 1'b1;
                    rs2_fwd = data_q[head_q + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    localparam int DATA_W = 32;
    localparam int EW     = DATA_W + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              lsu_valid = 1'b0;
    logic [4:0]        lsu_rd = '0;
    logic [DATA_W-1:0] lsu_data = '0;
    logic              lsu_ready;
    logic              alu_valid = 1'b0;
    logic [4:0]        alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic [4:0]        q_rs1 = '0;
    logic [4:0]        q_rs2 = '0;
    logic              rs1_hit, rs2_hit;
    logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
    logic [4:0]        addr_rd;
    logic [DATA_W-1:0] data_rd;
    logic              write_enable;

    reg_writeback_queue #(.DATA_W(DATA_W), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .addr_rd(addr_rd), .data_rd(data_rd), .write_enable(write_enable)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Compare the current register-file write against the oldest expected entry.
    task automatic check_write();
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we", 32'(write_enable), 32'd1);
            chk("addr_rd", 32'(addr_rd), 32'(e[EW-1:DATA_W]));
            chk("data_rd", data_rd, e[DATA_W-1:0]);
        end else begin
            chk("we_idle", 32'(write_enable), 32'd0);
            chk("addr_idle", 32'(addr_rd), 32'd0);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: check write output, present inputs, check readies and record
    // the transfers the bench expects to be enqueued.
    task automatic step(input bit lv, input logic [4:0] lrd, input logic [DATA_W-1:0] ld,
                        input bit av, input logic [4:0] ard, input logic [DATA_W-1:0] ad,
                        input bit exp_lr, input bit exp_ar);
        @(negedge clk);
        check_write();
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        #1;
        chk("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
        chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
        if (lv && exp_lr && lrd != 5'd0) exp_q.push_back({lrd, ld});
        if (av && exp_ar && ard != 5'd0) exp_q.push_back({ard, ad});
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        q_rs1 = 5'd5; q_rs2 = 5'd3;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(write_enable), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_we_rel", 32'(write_enable), 32'd0);
        chk("rst_addr", 32'(addr_rd), 32'd0);
        chk("rst_data", data_rd, 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_rs1_hit", 32'(rs1_hit), 32'd0);
        chk("rst_rs2_hit", 32'(rs2_hit), 32'd0);

        // Single ALU result; same-cycle input not visible to lookup
        step(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
        chk("alu_same_cycle_hit", 32'(rs1_hit), 32'd0);
        idle();
        chk("alu_rs1_hit", 32'(rs1_hit), 32'd1);
        chk("alu_rs1_fwd", rs1_fwd, 32'hDEADBEEF);
        idle();
        chk("alu_after_hit", 32'(rs1_hit), 32'd0);

        // Simultaneous completion to the same rd
        q_rs1 = 5'd3; q_rs2 = 5'd0;
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b1, 1'b1);
        chk("sim_same_cycle_hit", 32'(rs1_hit), 32'd0);
        idle();
        chk("sim_rs1_hit", 32'(rs1_hit), 32'd1);
        chk("sim_rs1_fwd_youngest", rs1_fwd, 32'h22);
        chk("sim_rs2_zero_hit", 32'(rs2_hit), 32'd0);
        chk("sim_rs2_zero_fwd", rs2_fwd, 32'd0);
        idle();
        chk("sim_rs1_fwd_last", rs1_fwd, 32'h22);
        idle();

        // Fill / backpressure: count 0 -> 2 -> 3 -> 3..., ALU blocked once free==1
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 5'(8 + 2 * k), 32'hA000_0000 | 32'(k),
                 1'b1, 5'(9 + 2 * k), 32'hB000_0000 | 32'(k),
                 1'b1, (k < 2));
        end
        repeat (4) idle();

        // rd=0 filtering
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 1'b1, 1'b1);
        idle();
        idle();

        // Async reset with three entries queued
        q_rs1 = 5'd22;
        step(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 1'b1, 1'b1);
        step(1'b1, 5'd22, 32'h220, 1'b1, 5'd23, 32'h230, 1'b1, 1'b1);
        @(negedge clk);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        chk("pre_rst_we", 32'(write_enable), 32'd1);
        chk("pre_rst_addr", 32'(addr_rd), 32'd21);
        chk("pre_rst_hit", 32'(rs1_hit), 32'd1);
        chk("pre_rst_fwd", rs1_fwd, 32'h220);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(write_enable), 32'd0);
        chk("arst_addr", 32'(addr_rd), 32'd0);
        chk("arst_hit", 32'(rs1_hit), 32'd0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        idle();
        idle();
        idle();

        // Operation resumes after reset
        step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
